// File: rtl/chip_timers.sv
// CHIP-8 frame divider, CPU-loadable 8-bit down-counters and gated speaker tone.
// Optional macro SPEAKER_DIFF_EN enables the complementary speaker_inv drive.
module chip_timers #(
    parameter int TICK_DIV   = 200000,
    parameter int NUM_TIMERS = 2,
    parameter int SOUND_CH   = 1,
    parameter int TONE_DIV   = 32768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       tick,
    output logic       vsync,
    output logic       beep,
    output logic       speaker,
    output logic       speaker_inv
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]  VSYNC_THR = DIV_W'(TICK_DIV / 2);
    localparam logic [TONE_W-1:0] TONE_LOAD = TONE_W'(TONE_DIV - 1);

    logic [DIV_W-1:0]  r_div;
    logic [7:0]        r_timer     [NUM_TIMERS];
    logic [7:0]        w_timer_nxt [NUM_TIMERS];
    logic [7:0]        w_rd;
    logic [TONE_W-1:0] r_tcnt;
    logic              r_tph;
    logic              w_tone_run;

    // Frame divider: tick is decoded from the terminal count, so it is 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= DIV_LOAD;
        end else if (r_div == '0) begin
            r_div <= DIV_LOAD;
        end else begin
            r_div <= r_div - 1'b1;
        end
    end

    assign tick  = (r_div == '0);
    assign vsync = (r_div < VSYNC_THR);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_timer_nxt[i] = r_timer[i];
            if (wr && (sel == 4'(i))) begin
                w_timer_nxt[i] = wdata;
            end else if (tick && (r_timer[i] != 8'd0)) begin
                w_timer_nxt[i] = r_timer[i] - 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_timer[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_timer[i] <= w_timer_nxt[i];
            end
        end
    end

    // Out-of-range selects match no channel and read back as 0.
    always_comb begin
        w_rd = 8'd0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (sel == 4'(i)) begin
                w_rd = r_timer[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 8'd0;
        end else begin
            rdata <= w_rd;
        end
    end

    assign beep = (r_timer[SOUND_CH] != 8'd0);

    // Stopping on the edge that clears the sound timer leaves the phase reset
    // for the very next cycle, so each onset starts with a full low half-period.
    assign w_tone_run = beep && (w_timer_nxt[SOUND_CH] != 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= TONE_LOAD;
            r_tph  <= 1'b0;
        end else if (!w_tone_run) begin
            r_tcnt <= TONE_LOAD;
            r_tph  <= 1'b0;
        end else if (r_tcnt == '0) begin
            r_tcnt <= TONE_LOAD;
            r_tph  <= ~r_tph;
        end else begin
            r_tcnt <= r_tcnt - 1'b1;
        end
    end

    assign speaker = r_tph & beep;

`ifdef SPEAKER_DIFF_EN
    assign speaker_inv = ~r_tph & beep;
`else
    assign speaker_inv = 1'b0;
`endif

endmodule

// File: tb/tb_chip_timers.sv
// Directed bench for chip_timers with TICK_DIV=10, TONE_DIV=3, NUM_TIMERS=2, SOUND_CH=1.
module tb_chip_timers;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sel = 4'd0;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       tick;
    logic       vsync;
    logic       beep;
    logic       speaker;
    logic       speaker_inv;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    chip_timers #(
        .TICK_DIV  (10),
        .NUM_TIMERS(2),
        .SOUND_CH  (1),
        .TONE_DIV  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .wr         (wr),
        .wdata      (wdata),
        .rdata      (rdata),
        .tick       (tick),
        .vsync      (vsync),
        .beep       (beep),
        .speaker    (speaker),
        .speaker_inv(speaker_inv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Cycle index counts from reset release; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_phase(input int ph);
        for (int k = 0; k < 10 && (cyc % 10) != ph; k++) step();
    endtask

    task automatic wr_timer(input logic [3:0] s, input logic [7:0] d);
        sel   = s;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
    endtask

    function automatic logic exp_inv(input logic b, input logic ph);
`ifdef SPEAKER_DIFF_EN
        return b & ~ph;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tick", tick, 0);
        check("rst_vsync", vsync, 0);
        check("rst_rdata", rdata, 0);
        check("rst_beep", beep, 0);
        check("rst_speaker", speaker, 0);
        check("rst_speaker_inv", speaker_inv, 0);
        rst = 1'b0;
        cyc = 0;

        // Idle: ticks at 9,19,29,39; vsync high on phases 5..9
        for (int c = 0; c < 40; c++) begin
            check("idle_tick", tick, ((cyc % 10) == 9) ? 1 : 0);
            check("idle_vsync", vsync, ((cyc % 10) >= 5) ? 1 : 0);
            step();
        end
        sel = 4'd0;
        step();
        check("idle_t0", rdata, 0);
        sel = 4'd1;
        step();
        check("idle_t1", rdata, 0);

        // timer0 = 3 counts down and saturates
        go_phase(0);
        wr_timer(4'd0, 8'd3);
        sel = 4'd0;
        step();
        check("t0_load", rdata, 3);
        begin
            logic [7:0] exp_seq [6] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
            for (int k = 0; k < 6; k++) begin
                step();
                go_phase(1);
                check($sformatf("t0_count%0d", k), rdata, exp_seq[k]);
            end
        end

        // timer1 = 2 gates the tone for two tick periods
        go_phase(0);
        wr_timer(4'd1, 8'd2);
        for (int k = 0; k < 21; k++) begin
            logic eb;
            logic ep;
            eb = (k < 19);
            ep = ((k / 3) % 2) == 1;
            check("snd_beep", beep, eb);
            check("snd_speaker", speaker, eb & ep);
            check("snd_speaker_inv", speaker_inv, exp_inv(eb, ep));
            step();
        end
        check("snd_t1_done", rdata, 0);

        // Write coinciding with a tick: written channel wins, other decrements
        wr_timer(4'd1, 8'd4);
        go_phase(9);
        check("coinc_tick", tick, 1);
        wr_timer(4'd0, 8'd5);
        sel = 4'd0;
        step();
        check("coinc_t0", rdata, 5);
        sel = 4'd1;
        step();
        check("coinc_t1", rdata, 3);
        check("coinc_beep", beep, 1);
        wr_timer(4'd1, 8'd0);
        check("silence_beep", beep, 0);
        check("silence_speaker", speaker, 0);
        check("silence_speaker_inv", speaker_inv, 0);

        // Out-of-range write is ignored
        wr_timer(4'd7, 8'd9);
        sel = 4'd7;
        step();
        check("oor_rd7", rdata, 0);
        sel = 4'd0;
        step();
        check("oor_t0", rdata, 5);
        sel = 4'd1;
        step();
        check("oor_t1", rdata, 0);

        // Reset mid-beep
        wr_timer(4'd1, 8'd10);
        check("mid_beep_on", beep, 1);
        repeat (4) step();
        check("mid_speaker_hi", speaker, 1);
        check("mid_speaker_inv", speaker_inv, exp_inv(1'b1, 1'b1));
        rst = 1'b1;
        #1;
        check("arst_beep", beep, 0);
        check("arst_speaker", speaker, 0);
        check("arst_speaker_inv", speaker_inv, 0);
        check("arst_tick", tick, 0);
        check("arst_vsync", vsync, 0);
        step();
        check("arst_rdata", rdata, 0);
        rst = 1'b0;
        cyc = 0;
        for (int c = 0; c < 12; c++) begin
            check("post_tick", tick, (cyc == 9 || cyc == 19) ? 1 : 0);
            check("post_beep", beep, 0);
            if (cyc >= 1) check("post_t1", rdata, 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chip_timers.md
# chip_timers

Parametrised timer and sound unit for the CHIP-8 console. It generates the frame tick and vsync square wave from the system clock, and holds NUM_TIMERS 8-bit down-counters that the CPU loads and reads; channel 0 is the delay timer and channel SOUND_CH is the sound timer. It drives a gated tone on the speaker pins. It replaces the free-running divider and speaker counter in the top level, and adds CPU-visible timer state, configurable rates and a differential speaker drive.

## Interface
Parameters:
- TICK_DIV, 200000: clk cycles per timer tick; must be ≥ 4.
- NUM_TIMERS, 2: number of 8-bit timer channels, 1..16.
- SOUND_CH, 1: index of the channel that gates the tone; must be < NUM_TIMERS.
- TONE_DIV, 32768: clk cycles per tone half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous reset, active-high.
- sel  in  4  timer channel select for read and write.
- wr  in  1  write strobe; loads wdata into timer[sel].
- wdata  in  8  load value.
- rdata  out  8  registered read of timer[sel].
- tick  out  1  one-cycle pulse per tick period.
- vsync  out  1  square wave at the tick rate, used as the CPU vsync.
- beep  out  1  high while the sound timer is non-zero.
- speaker  out  1  tone output.
- speaker_inv  out  1  complementary tone output; see Configuration.

## Operation
- Divider: down-counter div, reset value TICK_DIV-1. It decrements each cycle. When div==0, tick=1 for that cycle and div reloads to TICK_DIV-1.
- vsync = (div < TICK_DIV/2), using integer division, so vsync resets to 0.
- Timers:
  - timer[i] is 8-bit and resets to 0.
  - On a tick, every non-zero timer decrements by 1. Timers saturate at 0 and never wrap to 255.
- Write: on wr=1 with sel<NUM_TIMERS, timer[sel] ← wdata at the clock edge.
  - If the write coincides with a tick, the write wins for that channel: the value loaded is wdata, not wdata-1.
  - Other channels still decrement on that tick.
  - A write with sel≥NUM_TIMERS is ignored.
- Read: rdata ← (sel<NUM_TIMERS) ? timer[sel] : 0 every cycle. The value reflects timer state before that edge's updates.
- beep = (timer[SOUND_CH] != 0); it is combinational from the register.
- Tone generator:
  - Down-counter tcnt resets to TONE_DIV-1; phase bit tph resets to 0.
  - When tcnt==0, tph toggles and tcnt reloads.
  - While beep==0, tcnt is held at TONE_DIV-1 and tph at 0. Every beep onset therefore starts with a full-length low half-period.
- speaker = tph & beep.

## Timing
- Reset values: div=TICK_DIV-1; all timers 0; rdata=0; tick=0; vsync=0; beep=0; speaker=0; speaker_inv=0; tcnt=TONE_DIV-1; tph=0.
- First tick falls TICK_DIV-1 cycles after reset release. After that, tick has a period of exactly TICK_DIV cycles.
- Read latency: 1 cycle.
- A write is visible on rdata 2 cycles after wr is sampled: one cycle for the load, then the read register.
- beep rises in the cycle after the write edge that loads a non-zero value into SOUND_CH. It falls in the cycle after the tick that decrements the sound timer from 1 to 0.
- First speaker rising edge: TONE_DIV cycles after beep rises.
- Writing 0 to SOUND_CH silences the tone immediately: the next cycle has speaker=0 and the phase is reset.
- Asserting rst mid-count or mid-tone returns every register to its reset value immediately. No tick pulse is emitted on reset release.

## Configuration
- SPEAKER_DIFF_EN defined: speaker_inv = ~tph & beep. This gives a complementary drive while sounding, and both pins are 0 when silent.
- SPEAKER_DIFF_EN undefined: speaker_inv is tied to 0 and no extra logic is generated.

## Test plan
All scenarios use TICK_DIV=10, TONE_DIV=3, NUM_TIMERS=2, SOUND_CH=1.
- Reset then idle 40 cycles -> tick pulses at cycles 9, 19, 29, 39 after release; vsync high for 5 of every 10 cycles; all timers stay 0.
- Write timer0=3 -> rdata reads 3, then 2, 1, 0 on successive ticks; it then stays 0 through 3 further ticks, with no wrap.
- Write timer1=2 -> beep=1 for 2 tick periods. speaker is low for the first 3 cycles, then toggles every 3 cycles; beep and speaker are 0 after the second tick. With SPEAKER_DIFF_EN, speaker_inv is the complement of speaker while beeping.
- Write timer0=5 in the same cycle as a tick, with timer1=4 -> timer0 reads 5 and timer1 reads 3.
- Write with sel=7, wdata=9 -> no timer changes; rdata reads 0 for sel=7.
- Assert rst mid-beep with timer1=10 -> beep, speaker and speaker_inv drop to 0 asynchronously; timers are 0 after release; the first tick again arrives 9 cycles after release.
